pipelined_cla_addsub: RTL
=========================

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL have parameter N, default 32: operand/result width in bits, N >= 2.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth, 1 <= STAGES <= N, with N % STAGES == 0; SEG = N/STAGES bits per stage.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port op  input  1  operation select: 0 = add, 1 = subtract.
REQ-008 SHALL have port a  input  N  first operand.
REQ-009 SHALL have port b  input  N  second operand.
REQ-010 SHALL have port cin  input  1  carry-in for add, borrow-in for subtract.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port sum  output  N  result.
REQ-014 SHALL have port cout  output  1  carry out of bit N-1 (subtract: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port zero  output  1  sum == 0.
REQ-017 SHALL have port neg  output  1  sum[N-1].

Function
REQ-018 SHALL compute add as a + b + cin, and subtract as a + ~b + ~cin (i.e. a - b - cin), modulo 2^N.
REQ-019 SHALL use full carry-lookahead (generate/propagate) within each SEG-bit segment; no ripple chain inside a segment.
REQ-020 SHALL process segment k (bits k*SEG+SEG-1 .. k*SEG) in stage k, using the carry registered at the end of stage k-1; stage 0 uses the effective carry-in.
REQ-021 SHALL register per stage: valid bit, inter-segment carry, unprocessed upper operand bits (b already conditionally inverted), and completed lower sum bits.
REQ-022 SHALL give ovf = carry into bit N-1 XOR carry out of bit N-1.
REQ-023 SHALL present sum, cout, ovf, zero and neg from the final stage registers; zero and neg are derived from those registers.
REQ-024 SHALL accept a beat when in_valid && in_ready.
REQ-025 SHALL advance stage k when it holds valid data and stage k+1 is empty or advancing; the last stage advances on out_ready.
REQ-026 SHALL drive in_ready = stage 0 empty OR stage 0 advancing (no combinational dependency on in_valid).
REQ-027 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid when never stalled, with a throughput of one beat per cycle.
REQ-028 SHALL hold sum/cout/ovf/zero/neg stable while out_valid && !out_ready.
REQ-029 SHALL collapse bubbles: an empty stage SHALL be refilled even when downstream stalls.
REQ-030 SHALL buffer at most STAGES beats, preserve beat order, and never drop or duplicate a beat.
REQ-031 SHALL, when STAGES == 1, degenerate to a single registered N-bit CLA with the same handshake.

Reset
REQ-032 SHALL, while rst_n is low, asynchronously clear all stage valid bits, so that out_valid = 0 and in_ready = 1 after release.
REQ-033 SHALL, while rst_n is low, clear sum, cout, ovf and neg to 0 and set zero to 1.
REQ-034 SHALL discard in-flight beats on reset mid-operation and produce no out_valid until new input is accepted after release.

Verification (N=32, STAGES=4 unless stated)
REQ-035 SHALL pass: add a=0xFFFFFFFF b=0x00000001 cin=0, out_ready=1 -> 4 cycles later sum=0x00000000, cout=1, zero=1, ovf=0, neg=0.
REQ-036 SHALL pass: add a=0x7FFFFFFF b=0x00000001 cin=0 -> sum=0x80000000, ovf=1, neg=1, cout=0.
REQ-037 SHALL pass: sub a=0x80000000 b=0x00000001 cin=0 -> sum=0x7FFFFFFF, ovf=1, cout=1; sub a=0 b=1 cin=0 -> sum=0xFFFFFFFF, cout=0, neg=1.
REQ-038 SHALL pass: 10 back-to-back beats with out_ready=0 from cycle 2 -> in_ready drops after 4 beats are held, outputs stay stable; on out_ready=1 all 10 results emerge in order, one per cycle.
REQ-039 SHALL pass: rst_n pulsed low with 3 beats in flight -> out_valid=0 and in_ready=1 immediately; none of the 3 beats ever appears.
REQ-040 SHALL pass: N=8, STAGES=1, add 0x80+0x80 cin=1 -> after 1 cycle sum=0x01, cout=1, ovf=1.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: segmented carry-lookahead add/subtract with an elastic valid/ready pipeline
module pipelined_cla_addsub #(
  parameter int N = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);
  localparam int SEG = N / STAGES;
  localparam int L = STAGES - 1;

  logic [STAGES-1:0] v_q, v_in, ld;
  logic [N-1:0]      w_q [STAGES];
  logic [N-1:0]      w_d [STAGES];
  logic [N-1:0]      x_q [STAGES];
  logic [N-1:0]      x_d [STAGES];
  logic              c_q [STAGES];
  logic              c_d [STAGES];
  logic              o_q [STAGES];
  logic              o_d [STAGES];

  // Flat sum-of-products lookahead: every carry is formed directly from g/p and the segment carry-in.
  // Returns {carry out, carry into MSB, sum bits}.
  function automatic logic [SEG+1:0] cla(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic ci);
    logic [SEG-1:0] g, p;
    logic [SEG:0]   c;
    logic           t;
    g = x & y;
    p = x ^ y;
    for (int i = 0; i <= SEG; i++) begin
      c[i] = ci;
      for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[SEG], c[SEG-1], p ^ c[SEG-1:0]};
  endfunction

  // Stage k finishes segment k: w carries a's unprocessed bits above the completed sum bits,
  // x carries b already inverted for subtract, c is the carry handed to the next segment.
  genvar i;
  for (i = 0; i < STAGES; i++) begin : g_stg
    logic [N-1:0]   wi, xi;
    logic           ci;
    logic [SEG+1:0] r;
    if (i == 0) begin : g_head
      assign v_in[i] = in_valid;
      assign wi = a;
      assign xi = op ? ~b : b;
      assign ci = cin ^ op;
    end else begin : g_body
      assign v_in[i] = v_q[i-1];
      assign wi = w_q[i-1];
      assign xi = x_q[i-1];
      assign ci = c_q[i-1];
    end
    assign r = cla(wi[i*SEG +: SEG], xi[i*SEG +: SEG], ci);
    assign w_d[i] = (wi & ~(N'({SEG{1'b1}}) << (i*SEG))) | (N'(r[SEG-1:0]) << (i*SEG));
    assign x_d[i] = xi;
    assign c_d[i] = r[SEG+1];
    assign o_d[i] = r[SEG+1] ^ r[SEG];
  end

  // A stage may load when it or any later stage is empty, or the output is being taken.
  always_comb begin
    ld = '0;
    for (int k = 0; k < STAGES; k++) ld[k] = out_ready | (|(~v_q >> k));
  end

  // Stage registers: hold while blocked, otherwise take the upstream beat or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        w_q[k] <= '0;
        x_q[k] <= '0;
        c_q[k] <= 1'b0;
        o_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            w_q[k] <= w_d[k];
            x_q[k] <= x_d[k];
            c_q[k] <= c_d[k];
            o_q[k] <= o_d[k];
          end
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[L];
  assign sum       = w_q[L];
  assign cout      = c_q[L];
  assign ovf       = o_q[L];
  assign zero      = ~|w_q[L];
  assign neg       = w_q[L][N-1];
endmodule
